// File: rtl/spi_status_tx.sv
// spi_status_tx: snapshots renderer status and sends it to the SPI slave transmit
// interface as a fixed 8-byte packet, one byte per valid/ready handshake.
//
// Packet layout (byte index 0..7):
//   HEADER, PAYLOAD_LEN, fc[15:8], fc[7:0], status, {4'b0, cx[11:8]}, cx[7:0], CHK
//   CHK is the mod-256 sum of bytes 1..6 (the header is excluded).
//
// Ports:
//   CLK100MHZ  in   system clock, rising edge
//   ck_rst     in   asynchronous active-high reset
//   frame_done in   one-cycle pulse per rendered frame (16-bit frame counter)
//   send_req   in   one-cycle pulse requesting a status packet
//   status_in  in   controller status byte
//   circle_x   in   current circle x coordinate (12 bits)
//   tx_ready   in   SPI slave accepts a byte this cycle
//   tx_valid   out  tx_byte holds a valid packet byte
//   tx_byte    out  packet byte (0 when not valid)
//   busy       out  packet in flight or request pending
//   pkt_sent   out  one-cycle pulse after the last byte is accepted
//   overrun    out  sticky, a request was dropped (cleared only by reset)
module spi_status_tx #(
  parameter logic [7:0] HEADER      = 8'hA5,
  parameter logic [7:0] PAYLOAD_LEN = 8'd5
) (
  input  logic        CLK100MHZ,
  input  logic        ck_rst,
  input  logic        frame_done,
  input  logic        send_req,
  input  logic [7:0]  status_in,
  input  logic [11:0] circle_x,
  input  logic        tx_ready,
  output logic        tx_valid,
  output logic [7:0]  tx_byte,
  output logic        busy,
  output logic        pkt_sent,
  output logic        overrun
);

  typedef enum logic [1:0] {StIdle, StSend, StDone} state_e;

  state_e      state_q, state_d;
  logic [2:0]  idx_q, idx_d;
  logic        pending_q, pending_d;
  logic        overrun_q, overrun_d;
  logic [15:0] fc_q;
  logic [15:0] snap_fc_q;
  logic [7:0]  snap_status_q;
  logic [11:0] snap_cx_q;
  logic        snap_en;
  logic        xfer;
  logic [7:0]  chk_sum;
  logic [7:0]  pkt_byte;

  assign xfer = (state_q == StSend) && tx_ready;

  // Next-state, request queue and overrun tracking.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    pending_d = pending_q;
    overrun_d = overrun_q;
    snap_en   = 1'b0;
    case (state_q)
      StIdle: begin
        // A request arriving while one is pending merges into the same packet.
        if (send_req || pending_q) begin
          snap_en   = 1'b1;
          pending_d = 1'b0;
          idx_d     = 3'd0;
          state_d   = StSend;
        end
      end
      StSend: begin
        if (xfer) begin
          if (idx_q == 3'd7) begin
            state_d = StDone;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
        if (send_req) begin
          if (pending_q) overrun_d = 1'b1;
          else           pending_d = 1'b1;
        end
      end
      StDone: begin
        state_d = StIdle;
        if (send_req) begin
          if (pending_q) overrun_d = 1'b1;
          else           pending_d = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK100MHZ or posedge ck_rst) begin
    if (ck_rst) begin
      state_q       <= StIdle;
      idx_q         <= 3'd0;
      pending_q     <= 1'b0;
      overrun_q     <= 1'b0;
      fc_q          <= 16'd0;
      snap_fc_q     <= 16'd0;
      snap_status_q <= 8'd0;
      snap_cx_q     <= 12'd0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      pending_q <= pending_d;
      overrun_q <= overrun_d;
      if (frame_done) fc_q <= fc_q + 16'd1;
      // fc_q is the pre-increment value when frame_done coincides with the snapshot.
      if (snap_en) begin
        snap_fc_q     <= fc_q;
        snap_status_q <= status_in;
        snap_cx_q     <= circle_x;
      end
    end
  end

  // Packet byte selection, entirely from the snapshot.
  always_comb begin
    chk_sum = PAYLOAD_LEN + snap_fc_q[15:8] + snap_fc_q[7:0] + snap_status_q
            + {4'b0, snap_cx_q[11:8]} + snap_cx_q[7:0];
    pkt_byte = HEADER;
    case (idx_q)
      3'd0: pkt_byte = HEADER;
      3'd1: pkt_byte = PAYLOAD_LEN;
      3'd2: pkt_byte = snap_fc_q[15:8];
      3'd3: pkt_byte = snap_fc_q[7:0];
      3'd4: pkt_byte = snap_status_q;
      3'd5: pkt_byte = {4'b0, snap_cx_q[11:8]};
      3'd6: pkt_byte = snap_cx_q[7:0];
      3'd7: pkt_byte = chk_sum;
      default: pkt_byte = HEADER;
    endcase
  end

  // Outputs decode directly from registers so reset clears them without a clock edge.
  assign tx_valid = (state_q == StSend);
  assign tx_byte  = tx_valid ? pkt_byte : 8'd0;
  assign pkt_sent = (state_q == StDone);
  assign busy     = (state_q != StIdle) || pending_q;
  assign overrun  = overrun_q;

endmodule

// File: tb/tb_spi_status_tx.sv
module tb_spi_status_tx;

  logic        CLK100MHZ = 1'b0;
  logic        ck_rst;
  logic        frame_done;
  logic        send_req;
  logic [7:0]  status_in;
  logic [11:0] circle_x;
  logic        tx_ready;
  logic        tx_valid;
  logic [7:0]  tx_byte;
  logic        busy;
  logic        pkt_sent;
  logic        overrun;

  spi_status_tx dut (
    .CLK100MHZ (CLK100MHZ),
    .ck_rst    (ck_rst),
    .frame_done(frame_done),
    .send_req  (send_req),
    .status_in (status_in),
    .circle_x  (circle_x),
    .tx_ready  (tx_ready),
    .tx_valid  (tx_valid),
    .tx_byte   (tx_byte),
    .busy      (busy),
    .pkt_sent  (pkt_sent),
    .overrun   (overrun)
  );

  always #5 CLK100MHZ = ~CLK100MHZ;

  int          checks = 0;
  int          passes = 0;
  logic [7:0]  exp_q[$];
  logic [15:0] model_fc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Reference packet: header A5, length 05, fc, status, cx, sum of bytes 1..6.
  function automatic void push_pkt(input logic [15:0] fc, input logic [7:0] st,
                                   input logic [11:0] cx);
    logic [7:0] b[8];
    logic [7:0] s;
    b[0] = 8'hA5;
    b[1] = 8'h05;
    b[2] = fc[15:8];
    b[3] = fc[7:0];
    b[4] = st;
    b[5] = {4'h0, cx[11:8]};
    b[6] = cx[7:0];
    s = 8'h00;
    for (int k = 1; k < 7; k++) s = s + b[k];
    b[7] = s;
    for (int k = 0; k < 8; k++) exp_q.push_back(b[k]);
  endfunction

  // Scoreboard: every accepted byte is popped and compared.
  always @(negedge CLK100MHZ) begin
    logic [8:0] e;
    if (!ck_rst && tx_valid && tx_ready) begin
      e = (exp_q.size() > 0) ? {1'b0, exp_q.pop_front()} : 9'h100;
      chk("pkt_byte", {1'b0, tx_byte}, e);
    end
  end

  // Runs until npkts pkt_sent pulses (bounded). ev=1: change cx and pulse frame_done
  // mid-packet; ev=2: three send_req pulses during the packet.
  task automatic run_pkts(input bit toggle, input int ev, input int npkts,
                          output int vcyc, output int span, output int gap,
                          output int nsent);
    int first, last;
    logic [7:0] held;
    bit have_held;
    first = -1; last = -1; gap = -1; vcyc = 0; nsent = 0; have_held = 0; held = 8'h00;
    for (int i = 0; i < 80 && nsent < npkts; i++) begin
      @(negedge CLK100MHZ);
      if (tx_valid && nsent == 0) vcyc++;
      if (tx_valid && !tx_ready) begin
        held = tx_byte;
        have_held = 1;
      end else if (tx_valid && have_held) begin
        chk("hold_stable", tx_byte, held);
        have_held = 0;
      end
      if (tx_valid && tx_ready) begin
        if (nsent == 0) begin
          if (first < 0) first = i;
          last = i;
        end else if (gap < 0) begin
          gap = i - last - 1;
        end
      end
      if (pkt_sent) nsent++;
      @(posedge CLK100MHZ); #1;
      frame_done = 1'b0;
      send_req   = 1'b0;
      if (toggle) tx_ready = ~tx_ready;
      if (ev == 1 && i == 2) begin
        circle_x = 12'hFFF;
        frame_done = 1'b1;
        model_fc = model_fc + 16'd1;
      end
      if (ev == 2 && (i == 1 || i == 3 || i == 5)) begin
        send_req = 1'b1;
        if (i == 1) push_pkt(model_fc, status_in, circle_x);
      end
    end
    chk("pkt_sent_count", nsent, npkts);
    span = last - first + 1;
  endtask

  task automatic start_pkt();
    push_pkt(model_fc, status_in, circle_x);
    send_req = 1'b1;
    @(posedge CLK100MHZ); #1;
    send_req = 1'b0;
    chk("latency_valid", tx_valid, 1);
    chk("first_byte", tx_byte, 8'hA5);
  endtask

  task automatic do_reset();
    @(posedge CLK100MHZ); #2;
    ck_rst = 1'b1;
    #4;
    ck_rst = 1'b0;
    model_fc = 16'd0;
    exp_q.delete();
  endtask

  initial begin
    int vc, sp, gp, ns;
    ck_rst = 1'b1; frame_done = 1'b0; send_req = 1'b0;
    status_in = 8'h12; circle_x = 12'h0AB; tx_ready = 1'b1; model_fc = 16'd0;
    #3;
    chk("rst_tx_valid", tx_valid, 0);
    chk("rst_tx_byte", tx_byte, 0);
    chk("rst_busy", busy, 0);
    chk("rst_pkt_sent", pkt_sent, 0);
    chk("rst_overrun", overrun, 0);
    #9 ck_rst = 1'b0;

    // Basic packet at full rate.
    @(posedge CLK100MHZ); #1;
    repeat (3) begin
      frame_done = 1'b1;
      @(posedge CLK100MHZ); #1;
      frame_done = 1'b0;
      @(posedge CLK100MHZ); #1;
      model_fc = model_fc + 16'd1;
    end
    start_pkt();
    run_pkts(0, 0, 1, vc, sp, gp, ns);
    chk("full_valid_cycles", vc, 8);
    chk("full_span", sp, 8);
    chk("busy_after_done", busy, 0);

    // Ready toggling every cycle.
    start_pkt();
    run_pkts(1, 0, 1, vc, sp, gp, ns);
    chk("toggle_span", sp, 15);
    tx_ready = 1'b1;
    chk("toggle_busy_after", busy, 0);

    // Live inputs change mid-packet; next packet picks them up.
    start_pkt();
    run_pkts(0, 1, 1, vc, sp, gp, ns);
    start_pkt();
    run_pkts(0, 0, 1, vc, sp, gp, ns);
    chk("fc_after_mid", model_fc, 16'd4);

    // Frame counter wrap.
    do_reset();
    circle_x = 12'h0AB;
    @(posedge CLK100MHZ); #1;
    frame_done = 1'b1;
    repeat (65535) @(posedge CLK100MHZ);
    #1 frame_done = 1'b0;
    model_fc = 16'hFFFF;
    start_pkt();
    run_pkts(0, 0, 1, vc, sp, gp, ns);
    frame_done = 1'b1;
    @(posedge CLK100MHZ); #1;
    frame_done = 1'b0;
    model_fc = model_fc + 16'd1;
    start_pkt();
    run_pkts(0, 0, 1, vc, sp, gp, ns);

    // Three requests during one packet: one queued, two dropped.
    chk("overrun_before", overrun, 0);
    start_pkt();
    run_pkts(0, 2, 2, vc, sp, gp, ns);
    chk("pkt_gap", gp, 2);
    chk("overrun_set", overrun, 1);
    repeat (5) @(posedge CLK100MHZ);
    #1;
    chk("idle_after_two", busy, 0);
    chk("overrun_sticky", overrun, 1);

    // Asynchronous reset at byte index 4.
    start_pkt();
    repeat (4) @(posedge CLK100MHZ);
    #2;
    chk("idx4_byte", tx_byte, status_in);
    chk("overrun_pre_rst", overrun, 1);
    ck_rst = 1'b1;
    #1;
    chk("async_tx_valid", tx_valid, 0);
    chk("async_busy", busy, 0);
    chk("async_overrun", overrun, 0);
    chk("async_tx_byte", tx_byte, 0);
    exp_q.delete();
    model_fc = 16'd0;
    @(posedge CLK100MHZ); #3;
    ck_rst = 1'b0;
    @(posedge CLK100MHZ); #1;
    start_pkt();
    run_pkts(0, 0, 1, vc, sp, gp, ns);
    chk("queue_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/spi_status_tx.md
Name: spi_status_tx

Overview:
- Transmit-side counterpart to the SPI command receive path.
- Snapshots renderer status (frame count, controller status byte, current circle x) and serialises it into a fixed 8-byte framed packet with a checksum.
- Presents the packet one byte at a time to the SPI slave transmit interface using a valid/ready handshake.
- Sits beside the raytracing controller in the CLK100MHZ domain; the MCU reads the bytes out on its next SPI transfers.

Parameters:
- HEADER, 8'hA5, first byte of every packet.
- PAYLOAD_LEN, 8'd5, value sent in the length byte; fixed payload layout, not a structural size.

Ports:
- CLK100MHZ  input  1  system clock; all logic on the rising edge.
- ck_rst  input  1  reset, asynchronous, active-high.
- frame_done  input  1  one-cycle pulse at end of each rendered frame.
- send_req  input  1  one-cycle pulse requesting a status packet.
- status_in  input  8  controller status byte ({state[1:0], worker_any_busy, 5'b0} by convention).
- circle_x  input  12  current circle x coordinate.
- tx_ready  input  1  SPI slave can accept a byte this cycle.
- tx_valid  output  1  tx_byte holds a valid packet byte.
- tx_byte  output  8  packet byte.
- busy  output  1  packet in flight or request pending.
- pkt_sent  output  1  one-cycle pulse after the last byte is accepted.
- overrun  output  1  sticky; a request was dropped.

Behaviour:
- Reset (asynchronous, immediate): tx_valid=0, tx_byte=0, busy=0, pkt_sent=0, overrun=0, frame counter=0, pending=0, state=IDLE, byte index=0.
- Reset mid-packet aborts the packet with no further bytes. The SPI slave discards any partial packet.
- Frame counter: 16-bit, +1 on each frame_done, wraps 16'hFFFF -> 16'h0000. It counts in every state.
- Packet order, byte index 0..7:
  - HEADER
  - PAYLOAD_LEN
  - fc[15:8], fc[7:0]
  - status
  - {4'b0, cx[11:8]}, cx[7:0]
  - CHK
- CHK = 8-bit sum, mod 256, of bytes 1..6. The header is excluded.
- Snapshot:
  - fc, status and cx are registered in the cycle the packet starts. All bytes come from the snapshot, never live inputs.
  - If frame_done coincides with the snapshot, the snapshot takes the pre-increment counter value.
- States:
  - IDLE: tx_valid=0. On send_req or pending: take snapshot, clear pending, index=0, go to SEND. tx_valid=1 with HEADER from the next cycle, so request-to-first-byte latency is 1 cycle.
  - SEND: tx_valid=1, tx_byte=byte[index].
    - A byte transfers on any cycle with tx_valid && tx_ready.
    - On transfer with index<7: index+1; the next byte appears the following cycle.
    - On transfer with index==7: go to DONE.
    - While tx_ready=0, tx_byte and tx_valid hold stable indefinitely. There is no timeout.
  - DONE (1 cycle): tx_valid=0, pkt_sent=1, then IDLE. If pending=1, the next packet starts from IDLE per the IDLE rule, so the gap between packets is 2 cycles.
- Request queue is 1 deep:
  - send_req in SEND or DONE sets pending.
  - send_req while pending is already 1 is dropped and sets overrun=1. overrun clears only on reset.
  - send_req in IDLE while pending=1 merges into a single packet; no overrun.
- busy = (state != IDLE) || pending.
- Back-to-back transfers at full rate (tx_ready held high) give one byte per cycle, so 8 cycles of tx_valid per packet.

Test Plan:
- Reset, 3 frame_done pulses, status_in=8'h12, circle_x=12'h0AB, send_req with tx_ready=1 -> tx_valid high 1 cycle later for 8 consecutive cycles, bytes A5 05 00 03 12 00 AB C5, then pkt_sent pulse; busy low after DONE.
- Same stimulus with tx_ready toggling 1/0 every cycle -> identical byte sequence; each byte held stable through every ready-low cycle; 15 cycles from first to last byte.
- Change circle_x to 12'hFFF and pulse frame_done mid-packet -> the in-flight packet still carries 00 AB and fc 0003; the next packet shows fc 0004, bytes 0F FF.
- 65535 frame_done pulses from reset, then one more -> packet fc bytes FF FF, then 00 00; checksum of 05+00+00+12+00+AB = C2.
- send_req pulsed 3 times during one packet -> exactly 2 packets sent, 2-cycle gap between them, overrun=1 and stays 1 until ck_rst.
- Assert ck_rst asynchronously at byte index 4 -> tx_valid, busy and overrun drop immediately without a clock edge; after release, send_req yields a fresh packet starting with A5 and fc 0000.
